// File: rtl/uart_oversampled_tx.sv
// Oversampled UART transmitter: 8N1 framing with optional parity and one or two stop bits.
// Every output (tx, tx_busy, tx_done) is a flop; bit timing counts sample_en strobes.
module uart_oversampled_tx #(
    parameter int OVER_SAMPL     = 16,
    parameter int OVER_SAMPL_BIT = 5,
    parameter int PARITY_EN      = 0,
    parameter int PARITY_ODD     = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [OVER_SAMPL_BIT-1:0] TICK_LAST = OVER_SAMPL_BIT'(OVER_SAMPL - 1);
    localparam logic [2:0]                STOP_LAST = 3'(STOP_BITS - 1);

    state_t                    state_q, state_d;
    logic [OVER_SAMPL_BIT-1:0] tick_q, tick_d;
    logic [2:0]                bit_q, bit_d;
    logic [8:0]                sh_q, sh_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bit_end;
    logic                      par;

    // Handshake: tx_start is a request sampled only while tx_busy=0 (including
    // the tx_done cycle); while tx_busy=1 it is ignored and tx_data is not read.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bit_end = sample_en && (tick_q == TICK_LAST);
        par     = (^tx_data) ^ (PARITY_ODD != 0);

        if (state_q != IDLE && sample_en) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    sh_d    = {par, tx_data};
                    tick_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = sh_q[0];
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                // The shifter drops sent bits so the next one (data or parity) sits at [1].
                if (bit_end) begin
                    sh_d = {1'b1, sh_q[8:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            tx_d    = sh_q[1];
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    bit_d   = 3'd0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = 3'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            sh_q    <= '1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx        = tx_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_oversampled_tx.sv
// Bench for uart_oversampled_tx: four parameterisations share one stimulus stream and are
// checked every cycle against a pulse-count frame model, plus a byte scoreboard on unit 0.
module tb_uart_oversampled_tx;

    localparam int NU = 4;
    localparam int OS = 16;
    localparam int PEN [NU] = '{0, 1, 1, 0};
    localparam int PODD[NU] = '{0, 0, 1, 0};
    localparam int SB  [NU] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_en = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic       tx_o   [NU];
    logic       busy_o [NU];
    logic       done_o [NU];
    logic [2:0] st_o   [NU];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // frame model: pulses counted since acceptance select the current frame bit
    logic        m_busy [NU];
    logic        m_tx   [NU];
    logic        m_done [NU];
    logic        m_full [NU];
    logic [11:0] m_frame[NU];
    int          m_p    [NU];
    int          acc_cyc[NU];
    int          m_mid;

    logic [7:0] exp_q[$];
    logic [7:0] rx_byte;

    always #5 clk = ~clk;

    uart_oversampled_tx #(.OVER_SAMPL(OS), .OVER_SAMPL_BIT(5), .PARITY_EN(PEN[0]),
                          .PARITY_ODD(PODD[0]), .STOP_BITS(SB[0])) u0 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .tx_start(tx_start), .tx_data(tx_data),
        .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]), .state_dbg(st_o[0]));
    uart_oversampled_tx #(.OVER_SAMPL(OS), .OVER_SAMPL_BIT(5), .PARITY_EN(PEN[1]),
                          .PARITY_ODD(PODD[1]), .STOP_BITS(SB[1])) u1 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .tx_start(tx_start), .tx_data(tx_data),
        .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]), .state_dbg(st_o[1]));
    uart_oversampled_tx #(.OVER_SAMPL(OS), .OVER_SAMPL_BIT(5), .PARITY_EN(PEN[2]),
                          .PARITY_ODD(PODD[2]), .STOP_BITS(SB[2])) u2 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .tx_start(tx_start), .tx_data(tx_data),
        .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]), .state_dbg(st_o[2]));
    uart_oversampled_tx #(.OVER_SAMPL(OS), .OVER_SAMPL_BIT(5), .PARITY_EN(PEN[3]),
                          .PARITY_ODD(PODD[3]), .STOP_BITS(SB[3])) u3 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .tx_start(tx_start), .tx_data(tx_data),
        .tx(tx_o[3]), .tx_busy(busy_o[3]), .tx_done(done_o[3]), .state_dbg(st_o[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int flen(input int k);
        return 9 + PEN[k] + SB[k];
    endfunction

    task automatic model_step();
        m_mid = 0;
        for (int k = 0; k < NU; k++) begin
            m_done[k] = 1'b0;
            if (!rst) begin
                m_busy[k] = 1'b0;
                m_tx[k]   = 1'b1;
                if (k == 0) exp_q.delete();
            end else if (!m_busy[k]) begin
                m_tx[k] = 1'b1;
                if (tx_start) begin
                    m_frame[k]      = '1;
                    m_frame[k][0]   = 1'b0;
                    m_frame[k][8:1] = tx_data;
                    if (PEN[k] != 0) m_frame[k][9] = (^tx_data) ^ (PODD[k] != 0);
                    m_busy[k]  = 1'b1;
                    m_p[k]     = 0;
                    m_tx[k]    = 1'b0;
                    m_full[k]  = 1'b1;
                    acc_cyc[k] = cyc;
                    if (k == 0) exp_q.push_back(tx_data);
                end
            end else begin
                if (!sample_en) m_full[k] = 1'b0;
                if (sample_en) begin
                    m_p[k]++;
                    if (m_p[k] == flen(k) * OS) begin
                        m_busy[k] = 1'b0;
                        m_done[k] = 1'b1;
                        m_tx[k]   = 1'b1;
                    end else begin
                        m_tx[k] = m_frame[k][m_p[k] / OS];
                        if (k == 0 && m_p[k] % OS == OS / 2 && m_p[k] / OS >= 1 && m_p[k] / OS <= 8)
                            m_mid = m_p[k] / OS;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NU; k++) begin
            check_eq($sformatf("tx%0d", k), tx_o[k], m_tx[k]);
            check_eq($sformatf("busy%0d", k), busy_o[k], m_busy[k]);
            check_eq($sformatf("done%0d", k), done_o[k], m_done[k]);
            check_eq($sformatf("idle_state%0d", k), st_o[k] == 3'd0, !m_busy[k]);
            if (done_o[k] && m_full[k])
                check_eq($sformatf("frame_len%0d", k), cyc - acc_cyc[k], flen(k) * OS);
        end
        if (m_mid > 0) rx_byte[m_mid-1] = tx_o[0];
        if (done_o[0]) begin
            check_eq("sb_q_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("sb_byte0", rx_byte, exp_q.pop_front());
        end
    endtask

    task automatic cycle(input logic r, input logic se, input logic st, input logic [7:0] d);
        rst = r;
        sample_en = se;
        tx_start = st;
        tx_data = d;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
    endtask

    initial begin
        logic [7:0] dir_data[3];
        logic [7:0] cur_d;
        int         n_done;
        for (int k = 0; k < NU; k++) begin
            m_busy[k] = 1'b0; m_tx[k] = 1'b1; m_done[k] = 1'b0; m_full[k] = 1'b0;
            m_frame[k] = '1; m_p[k] = 0; acc_cyc[k] = 0;
        end
        m_mid = 0;
        rx_byte = 8'h00;

        // reset, with tx_start asserted to show it has no effect
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 8'hFF);

        // full-rate directed frames, including explicit parity-bit probes
        dir_data[0] = 8'hA5;
        dir_data[1] = 8'h07;
        dir_data[2] = 8'($urandom);
        for (int j = 0; j < 3; j++) begin
            cycle(1'b1, 1'b1, 1'b1, dir_data[j]);
            for (int i = 1; i <= 200; i++) begin
                cycle(1'b1, 1'b1, 1'b0, 8'h00);
                if (j == 1 && i == 9 * OS + 8) begin
                    check_eq("par_even_07", tx_o[1], 1'b1);
                    check_eq("par_odd_07", tx_o[2], 1'b0);
                end
                if (j == 0 && i == 3 * OS + 8) check_eq("a5_bit2", tx_o[0], 1'b1);
            end
        end

        // quarter-rate strobe, 8'h00, second tx_start mid-frame
        for (int i = 0; i < 800; i++)
            cycle(1'b1, i % 4 == 0, i == 0 || i == 300, i == 300 ? 8'hFF : 8'h00);

        // tx_start held high: 8'h55, switched to 8'hAA on the first tx_done cycle
        cur_d = 8'h55;
        n_done = 0;
        for (int i = 0; i < 1000 && n_done < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b1, cur_d);
            if (done_o[0]) begin
                n_done++;
                cur_d = 8'hAA;
            end
        end
        check_eq("b2b_frame_count", n_done, 2);
        drain(200);

        // one-cycle reset during data bit 3, then an immediate new frame
        cycle(1'b1, 1'b1, 1'b1, 8'h3C);
        for (int i = 0; i < 100 && m_p[0] != 4 * OS + 5; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("abort_tx", tx_o[0], 1'b1);
        check_eq("abort_busy", busy_o[0], 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 8'hC3);
        check_eq("reaccept_busy", busy_o[0], 1'b1);
        check_eq("reaccept_tx", tx_o[0], 1'b0);
        drain(200);

        // strobe stalled mid-frame: everything must freeze
        cycle(1'b1, 1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'($urandom), 8'($urandom));
        drain(200);

        // random traffic with sparse resets
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 499) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 9) == 0, 8'($urandom));
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
